// File: rtl/axi_lite_apb_frontend.sv
// AXI4-Lite slave front end: one-deep AW/W/AR buffers feeding one APB command at a time; `AXI_APB_FE_RR_ARB_EN selects round-robin arbitration.
// Latency: last AW/W (or AR) handshake at edge N -> start_* high from cycle N+2; response valid the cycle after the completion strobe.
// Backpressure: s_*ready drop while a buffer is full; B/R are held until s_bready/s_rready.
module axi_lite_apb_frontend #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            apb_clk,
   input  logic            sys_areset,
   input  logic [AW-1:0]   s_awaddr,
   input  logic [2:0]      s_awprot,
   input  logic            s_awvalid,
   output logic            s_awready,
   input  logic [DW-1:0]   s_wdata,
   input  logic [DW/8-1:0] s_wstrb,
   input  logic            s_wvalid,
   output logic            s_wready,
   output logic [1:0]      s_bresp,
   output logic            s_bvalid,
   input  logic            s_bready,
   input  logic [AW-1:0]   s_araddr,
   input  logic [2:0]      s_arprot,
   input  logic            s_arvalid,
   output logic            s_arready,
   output logic [DW-1:0]   s_rdata,
   output logic [1:0]      s_rresp,
   output logic            s_rvalid,
   input  logic            s_rready,
   output logic            start_write,
   output logic            start_read,
   output logic [AW-1:0]   write_address,
   output logic [AW-1:0]   read_address,
   output logic [DW-1:0]   write_data,
   output logic [DW/8-1:0] be,
   output logic [2:0]      wprot,
   output logic [2:0]      rprot,
   input  logic [DW-1:0]   read_data,
   input  logic            read_data_valid,
   input  logic            done_write,
   input  logic            slv_err
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR_REQ  = 3'd1;
   localparam logic [2:0] WR_RESP = 3'd2;
   localparam logic [2:0] RD_REQ  = 3'd3;
   localparam logic [2:0] RD_RESP = 3'd4;

   logic [2:0] state;
   logic       aw_full, w_full, ar_full;
   logic       wr_elig, rd_elig, grant_rd, grant_wr;

   assign s_awready = ~aw_full;
   assign s_wready  = ~w_full;
   assign s_arready = ~ar_full;
   assign wr_elig   = aw_full & w_full;
   assign rd_elig   = ar_full;

`ifdef AXI_APB_FE_RR_ARB_EN
   // 1 = last grant went to read; reset value means "write", so read wins the first tie.
   logic last_grant_rd;

   always_comb begin
      grant_rd = rd_elig & (~wr_elig | ~last_grant_rd);
      grant_wr = wr_elig & ~grant_rd;
   end

   always_ff @(posedge apb_clk or posedge sys_areset) begin
      if (sys_areset)
         last_grant_rd <= 1'b0;
      else if (state == IDLE && (grant_rd || grant_wr))
         last_grant_rd <= grant_rd;
   end
`else
   always_comb begin
      grant_rd = rd_elig;
      grant_wr = wr_elig & ~rd_elig;
   end
`endif

   always_ff @(posedge apb_clk or posedge sys_areset) begin
      if (sys_areset) begin
         state         <= IDLE;
         aw_full       <= 1'b0;
         w_full        <= 1'b0;
         ar_full       <= 1'b0;
         write_address <= '0;
         wprot         <= '0;
         write_data    <= '0;
         be            <= '0;
         read_address  <= '0;
         rprot         <= '0;
         start_write   <= 1'b0;
         start_read    <= 1'b0;
         s_bvalid      <= 1'b0;
         s_bresp       <= 2'b00;
         s_rvalid      <= 1'b0;
         s_rresp       <= 2'b00;
         s_rdata       <= '0;
      end else begin
         // A buffer can only be loaded while empty, so loads never collide with the clears below.
         if (s_awvalid && !aw_full) begin
            aw_full       <= 1'b1;
            write_address <= s_awaddr;
            wprot         <= s_awprot;
         end
         if (s_wvalid && !w_full) begin
            w_full     <= 1'b1;
            write_data <= s_wdata;
            be         <= s_wstrb;
         end
         if (s_arvalid && !ar_full) begin
            ar_full      <= 1'b1;
            read_address <= s_araddr;
            rprot        <= s_arprot;
         end

         case (state)
            IDLE: begin
               if (grant_rd) begin
                  start_read <= 1'b1;
                  state      <= RD_REQ;
               end else if (grant_wr) begin
                  start_write <= 1'b1;
                  state       <= WR_REQ;
               end
            end
            WR_REQ: begin
               // start_write must fall on this edge or the APB FSM launches the write again.
               if (done_write) begin
                  start_write <= 1'b0;
                  aw_full     <= 1'b0;
                  w_full      <= 1'b0;
                  s_bresp     <= slv_err ? 2'b10 : 2'b00;
                  s_bvalid    <= 1'b1;
                  state       <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (s_bready) begin
                  s_bvalid <= 1'b0;
                  state    <= IDLE;
               end
            end
            RD_REQ: begin
               if (read_data_valid) begin
                  start_read <= 1'b0;
                  ar_full    <= 1'b0;
                  s_rdata    <= read_data;
                  s_rresp    <= slv_err ? 2'b10 : 2'b00;
                  s_rvalid   <= 1'b1;
                  state      <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (s_rready) begin
                  s_rvalid <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_apb_frontend.sv
// Self-checking bench for axi_lite_apb_frontend: directed scenarios plus randomized traffic against a request-order model.
module tb_axi_lite_apb_frontend;
   localparam int AW = 32;
   localparam int DW = 32;
`ifdef AXI_APB_FE_RR_ARB_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic            apb_clk = 1'b0;
   logic            sys_areset;
   logic [AW-1:0]   s_awaddr, s_araddr, write_address, read_address;
   logic [2:0]      s_awprot, s_arprot, wprot, rprot;
   logic            s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic            s_arvalid, s_arready, s_rvalid, s_rready;
   logic [DW-1:0]   s_wdata, s_rdata, write_data, read_data;
   logic [DW/8-1:0] s_wstrb, be;
   logic [1:0]      s_bresp, s_rresp;
   logic            start_write, start_read, read_data_valid, done_write, slv_err;

   int   total = 0;
   int   bad = 0;
   logic last_rd;   // model: direction of the most recent grant (0 = write)

   always #5 apb_clk = ~apb_clk;

   axi_lite_apb_frontend #(.AW(AW), .DW(DW)) dut (
      .apb_clk(apb_clk), .sys_areset(sys_areset),
      .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .start_write(start_write), .start_read(start_read),
      .write_address(write_address), .read_address(read_address),
      .write_data(write_data), .be(be), .wprot(wprot), .rprot(rprot),
      .read_data(read_data), .read_data_valid(read_data_valid),
      .done_write(done_write), .slv_err(slv_err)
   );

   task automatic tick();
      @(posedge apb_clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      sys_areset = 1'b1;
      #2;
      sys_areset = 1'b0;
      last_rd = 1'b0;
   endtask

   task automatic send_aw(input logic [31:0] a, input logic [2:0] p);
      s_awaddr = a; s_awprot = p; s_awvalid = 1'b1;
      tick();
      s_awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
      tick();
      s_wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] a, input logic [2:0] p);
      s_araddr = a; s_arprot = p; s_arvalid = 1'b1;
      tick();
      s_arvalid = 1'b0;
   endtask

   // Waits (bounded) for a command; on timeout both flags come back 0.
   task automatic wait_start(output logic rd, output logic wr);
      int n = 0;
      while (!(start_read || start_write) && n < 50) begin
         tick();
         n++;
      end
      rd = start_read;
      wr = start_write;
   endtask

   // Pulses the completion strobe, then holds the response ready low for dly cycles before accepting it.
   task automatic finish_xfer(input logic is_rd, input logic err, input logic [31:0] rdat, input int dly,
                              output logic vld, output logic [1:0] resp, output logic [31:0] data,
                              output logic st_after, output logic vld_held, output logic vld_after);
      if (is_rd) begin
         read_data = rdat;
         read_data_valid = 1'b1;
      end else begin
         done_write = 1'b1;
      end
      slv_err = err;
      tick();
      read_data_valid = 1'b0; done_write = 1'b0; slv_err = 1'b0;
      vld = is_rd ? s_rvalid : s_bvalid;
      resp = is_rd ? s_rresp : s_bresp;
      data = s_rdata;
      st_after = start_read | start_write;
      repeat (dly) tick();
      vld_held = is_rd ? s_rvalid : s_bvalid;
      if (is_rd) s_rready = 1'b1; else s_bready = 1'b1;
      tick();
      vld_after = is_rd ? s_rvalid : s_bvalid;
      s_rready = 1'b0; s_bready = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin bad++; $display("FAIL reset_ready got=%b exp=111", {s_awready, s_wready, s_arready}); end
      total++; if ({start_read, start_write, s_bvalid, s_rvalid} !== 4'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=0000", {start_read, start_write, s_bvalid, s_rvalid}); end
      total++; if ({s_bresp, s_rresp, s_rdata} !== '0) begin bad++; $display("FAIL reset_resp got=%h exp=0", {s_bresp, s_rresp, s_rdata}); end
      total++; if ({write_address, read_address, write_data, be, wprot, rprot} !== '0) begin bad++; $display("FAIL reset_bufs got=%h exp=0", {write_address, read_address, write_data, be, wprot, rprot}); end
   endtask

   task automatic test_write_basic();
      logic vld, st, held, after; logic [1:0] resp; logic [31:0] d;
      send_w(32'hDEADBEEF, 4'hF);
      send_aw(32'h10, 3'b010);
      total++; if ({start_write, s_awready, s_wready} !== 3'b000) begin bad++; $display("FAIL wr_latency_early got=%b exp=000", {start_write, s_awready, s_wready}); end
      tick();
      total++; if ({start_write, start_read} !== 2'b10) begin bad++; $display("FAIL wr_start got=%b exp=10", {start_write, start_read}); end
      total++; if ({write_address, write_data, be, wprot} !== {32'h10, 32'hDEADBEEF, 4'hF, 3'b010}) begin bad++; $display("FAIL wr_fields got=%h exp=%h", {write_address, write_data, be, wprot}, {32'h10, 32'hDEADBEEF, 4'hF, 3'b010}); end
      tick();
      total++; if (start_write !== 1'b1) begin bad++; $display("FAIL wr_start_hold got=%b exp=1", start_write); end
      last_rd = 1'b0;
      finish_xfer(1'b0, 1'b0, 32'h0, 0, vld, resp, d, st, held, after);
      total++; if ({st, vld, resp} !== 4'b0100) begin bad++; $display("FAIL wr_done got=%b exp=0100", {st, vld, resp}); end
      total++; if (after !== 1'b0) begin bad++; $display("FAIL wr_b_release got=%b exp=0", after); end
   endtask

   task automatic test_read_err();
      logic vld, st, held, after; logic [1:0] resp; logic [31:0] d;
      send_ar(32'h20, 3'b101);
      tick();
      total++; if ({start_read, start_write, read_address, rprot} !== {2'b10, 32'h20, 3'b101}) begin bad++; $display("FAIL rd_start got=%h exp=%h", {start_read, start_write, read_address, rprot}, {2'b10, 32'h20, 3'b101}); end
      last_rd = 1'b1;
      finish_xfer(1'b1, 1'b1, 32'h12345678, 4, vld, resp, d, st, held, after);
      total++; if ({st, vld, resp, d} !== {2'b01, 2'b10, 32'h12345678}) begin bad++; $display("FAIL rd_resp got=%h exp=%h", {st, vld, resp, d}, {2'b01, 2'b10, 32'h12345678}); end
      total++; if ({held, after} !== 2'b10) begin bad++; $display("FAIL rd_hold got=%b exp=10", {held, after}); end
   endtask

   task automatic test_arbitration();
      logic rd, wr, exp_rd, vld, st, held, after; logic [1:0] resp; logic [31:0] d;
      do_reset();
      for (int r = 0; r < 2; r++) begin
         s_awaddr = $urandom; s_awprot = 3'($urandom); s_wdata = $urandom; s_wstrb = 4'($urandom);
         s_araddr = $urandom; s_arprot = 3'($urandom);
         s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
         tick();
         s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
         for (int g = 0; g < 2; g++) begin
            exp_rd = (g == 0) ? (RR ? ~last_rd : 1'b1) : ~last_rd;
            wait_start(rd, wr);
            total++; if ({rd, wr} !== {exp_rd, ~exp_rd}) begin bad++; $display("FAIL arb_grant r=%0d g=%0d got=%b exp=%b", r, g, {rd, wr}, {exp_rd, ~exp_rd}); end
            last_rd = exp_rd;
            finish_xfer(exp_rd, 1'b0, 32'h0, 0, vld, resp, d, st, held, after);
            total++; if ({vld, resp, after} !== 4'b1000) begin bad++; $display("FAIL arb_resp got=%b exp=1000", {vld, resp, after}); end
         end
      end
   endtask

   task automatic test_b_backpressure();
      logic rd, wr, vld, st, held, after; logic [1:0] resp; logic [31:0] d;
      logic [31:0] a2;
      s_awaddr = 32'h40; s_awprot = 3'b000; s_wdata = 32'hA5A5A5A5; s_wstrb = 4'h3;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      wait_start(rd, wr);
      total++; if ({rd, wr} !== 2'b01) begin bad++; $display("FAIL bp_first got=%b exp=01", {rd, wr}); end
      last_rd = 1'b0;
      done_write = 1'b1;
      tick();
      done_write = 1'b0;
      a2 = $urandom;
      s_awaddr = a2; s_awprot = 3'b001; s_wdata = $urandom; s_wstrb = 4'hC;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      total++; if ({s_awready, s_wready} !== 2'b00) begin bad++; $display("FAIL bp_buffered got=%b exp=00", {s_awready, s_wready}); end
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if ({start_write, s_bvalid} !== 2'b01) begin bad++; $display("FAIL bp_hold cyc=%0d got=%b exp=01", i, {start_write, s_bvalid}); end
      end
      s_bready = 1'b1;
      tick();
      s_bready = 1'b0;
      total++; if ({s_bvalid, start_write} !== 2'b00) begin bad++; $display("FAIL bp_release got=%b exp=00", {s_bvalid, start_write}); end
      tick();
      total++; if ({start_write, write_address} !== {1'b1, a2}) begin bad++; $display("FAIL bp_issue got=%h exp=%h", {start_write, write_address}, {1'b1, a2}); end
      finish_xfer(1'b0, 1'b1, 32'h0, 1, vld, resp, d, st, held, after);
      total++; if ({vld, resp, after} !== 4'b1100) begin bad++; $display("FAIL bp_resp got=%b exp=1100", {vld, resp, after}); end
   endtask

   task automatic test_reset_mid();
      send_ar(32'h80, 3'b011);
      tick();
      total++; if (start_read !== 1'b1) begin bad++; $display("FAIL rm_pre got=%b exp=1", start_read); end
      #2;
      sys_areset = 1'b1;
      #1;
      total++; if ({start_read, s_rvalid, s_awready, s_wready, s_arready, read_address} !== {5'b00111, 32'h0}) begin bad++; $display("FAIL rm_async got=%h exp=%h", {start_read, s_rvalid, s_awready, s_wready, s_arready, read_address}, {5'b00111, 32'h0}); end
      #1;
      sys_areset = 1'b0;
      last_rd = 1'b0;
      read_data = 32'hCAFEF00D; read_data_valid = 1'b1;
      tick();
      read_data_valid = 1'b0;
      tick();
      total++; if ({s_rvalid, start_read, start_write} !== 3'b000) begin bad++; $display("FAIL rm_no_resp got=%b exp=000", {s_rvalid, start_read, start_write}); end
   endtask

   task automatic test_stray();
      logic rd, wr;
      done_write = 1'b1; slv_err = 1'b1;
      tick();
      done_write = 1'b0; slv_err = 1'b0;
      total++; if ({s_bvalid, start_write, s_awready, s_wready} !== 4'b0011) begin bad++; $display("FAIL stray_dw got=%b exp=0011", {s_bvalid, start_write, s_awready, s_wready}); end
      read_data_valid = 1'b1;
      tick();
      read_data_valid = 1'b0;
      total++; if ({s_rvalid, start_read} !== 2'b00) begin bad++; $display("FAIL stray_rdv got=%b exp=00", {s_rvalid, start_read}); end
      send_ar(32'h44, 3'b000);
      wait_start(rd, wr);
      total++; if ({rd, wr} !== 2'b10) begin bad++; $display("FAIL stray_after got=%b exp=10", {rd, wr}); end
      last_rd = 1'b1;
      read_data_valid = 1'b1;
      tick();
      read_data_valid = 1'b0;
      s_rready = 1'b1;
      tick();
      s_rready = 1'b0;
   endtask

   task automatic test_random();
      logic rd, wr, dir, first_rd, pw, pr, err, vld, st, held, after;
      logic [1:0] resp; logic [31:0] d, rdat;
      logic [31:0] aw_a, w_d, ar_a; logic [3:0] w_s; logic [2:0] aw_p, ar_p;
      int aw_o, w_o, ar_o, wr_t, k;
      for (int it = 0; it < 25; it++) begin
         k = $urandom_range(1, 3);
         pw = k[0]; pr = k[1];
         aw_o = $urandom_range(0, 2); w_o = $urandom_range(0, 2); ar_o = $urandom_range(0, 2);
         aw_a = $urandom; w_d = $urandom; ar_a = $urandom;
         w_s = 4'($urandom); aw_p = 3'($urandom); ar_p = 3'($urandom);
         for (int c = 0; c < 3; c++) begin
            s_awaddr = aw_a; s_awprot = aw_p; s_wdata = w_d; s_wstrb = w_s; s_araddr = ar_a; s_arprot = ar_p;
            s_awvalid = pw && aw_o == c;
            s_wvalid  = pw && w_o == c;
            s_arvalid = pr && ar_o == c;
            tick();
            s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
         end
         // The earlier-complete request goes first; a tie is settled by the arbitration policy.
         wr_t = (aw_o > w_o) ? aw_o : w_o;
         if (pr && pw)
            first_rd = (ar_o < wr_t) ? 1'b1 : (wr_t < ar_o) ? 1'b0 : (RR ? ~last_rd : 1'b1);
         else
            first_rd = pr;
         for (int n = 0; n < (pr && pw ? 2 : 1); n++) begin
            dir = (n == 0) ? first_rd : ~first_rd;
            wait_start(rd, wr);
            total++; if ({rd, wr} !== {dir, ~dir}) begin bad++; $display("FAIL rnd_grant it=%0d n=%0d got=%b exp=%b", it, n, {rd, wr}, {dir, ~dir}); end
            if (dir) begin
               total++; if ({read_address, rprot} !== {ar_a, ar_p}) begin bad++; $display("FAIL rnd_rd_cmd it=%0d got=%h exp=%h", it, {read_address, rprot}, {ar_a, ar_p}); end
            end else begin
               total++; if ({write_address, wprot, write_data, be} !== {aw_a, aw_p, w_d, w_s}) begin bad++; $display("FAIL rnd_wr_cmd it=%0d got=%h exp=%h", it, {write_address, wprot, write_data, be}, {aw_a, aw_p, w_d, w_s}); end
            end
            last_rd = dir;
            err = 1'($urandom);
            rdat = $urandom;
            finish_xfer(dir, err, rdat, $urandom_range(0, 3), vld, resp, d, st, held, after);
            total++; if ({st, vld, held, after, resp} !== {4'b0110, err, 1'b0}) begin bad++; $display("FAIL rnd_resp it=%0d got=%b exp=%b", it, {st, vld, held, after, resp}, {4'b0110, err, 1'b0}); end
            if (dir) begin
               total++; if (d !== rdat) begin bad++; $display("FAIL rnd_rdata it=%0d got=%h exp=%h", it, d, rdat); end
            end
         end
      end
   endtask

   initial begin
      sys_areset = 1'b1;
      s_awaddr = '0; s_awprot = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
      s_bready = 1'b0; s_araddr = '0; s_arprot = '0; s_arvalid = 1'b0; s_rready = 1'b0;
      read_data = '0; read_data_valid = 1'b0; done_write = 1'b0; slv_err = 1'b0;
      last_rd = 1'b0;
      test_reset();
      test_write_basic();
      test_read_err();
      test_arbitration();
      test_b_backpressure();
      test_reset_mid();
      test_stray();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi_lite_apb_frontend.md
Name: axi_lite_apb_frontend

Overview:
AXI4-Lite slave front end of the AXI-Lite-to-APB bridge. It sits directly upstream of the APB master FSM.
- Accepts AW/W/AR channels independently and buffers one request of each.
- Arbitrates between read and write, and drives the FSM's start/address/data command inputs.
- Converts the FSM's completion strobes into B/R channel responses.
- One outstanding APB transfer at a time.

Parameters:
AW, 32, address width (AXI and APB side identical)
DW, 32, data width; strobe width DW/8

Ports:
apb_clk  in  1  single clock for the whole block
sys_areset  in  1  asynchronous, active-high reset
s_awaddr  in  AW  write address
s_awprot  in  3  write protection
s_awvalid  in  1  AW valid
s_awready  out  1  AW ready
s_wdata  in  DW  write data
s_wstrb  in  DW/8  write strobes
s_wvalid  in  1  W valid
s_wready  out  1  W ready
s_bresp  out  2  write response
s_bvalid  out  1  B valid
s_bready  in  1  B ready
s_araddr  in  AW  read address
s_arprot  in  3  read protection
s_arvalid  in  1  AR valid
s_arready  out  1  AR ready
s_rdata  out  DW  read data
s_rresp  out  2  read response
s_rvalid  out  1  R valid
s_rready  in  1  R ready
start_write  out  1  write command level to APB FSM
start_read  out  1  read command level to APB FSM
write_address  out  AW  buffered AW address
read_address  out  AW  buffered AR address
write_data  out  DW  buffered W data
be  out  DW/8  buffered W strobes
wprot  out  3  buffered AW prot
rprot  out  3  buffered AR prot
read_data  in  DW  APB read data
read_data_valid  in  1  read completion strobe (1 cycle)
done_write  in  1  write completion strobe (1 cycle)
slv_err  in  1  APB error, valid with the completion strobes

Behaviour:
- Reset (async, immediate): all buffers empty; FSM to IDLE. The following outputs are 0: start_*, s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata, all address/data/prot/be outputs. s_awready, s_wready and s_arready = 1 after reset because the buffers are empty.
- Reset mid-transfer: the in-flight transfer is dropped and no response is issued.
- Buffers:
  - aw_full, w_full, ar_full, one entry each.
  - s_xready = ~x_full; a handshake loads the buffer and sets full on the same edge.
  - AW and W are accepted in either order or in the same cycle.
  - Buffer outputs drive write_address/wprot/write_data/be/read_address/rprot directly and stay stable while full.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
  - IDLE:
    - Write is eligible when aw_full & w_full; read is eligible when ar_full.
    - With a grant, start_x is registered to 1 on the transition edge.
    - Default arbitration is fixed read priority.
  - WR_REQ: start_write held high until done_write. On that edge:
    - start_write <= 0, so it is low the very next cycle; this is mandatory, or the FSM restarts.
    - aw_full/w_full cleared.
    - s_bresp <= slv_err ? 2'b10 : 2'b00; s_bvalid <= 1.
    - Go to WR_RESP.
  - WR_RESP: hold B until s_bvalid & s_bready, then s_bvalid <= 0 and go to IDLE.
  - RD_REQ: symmetric on read_data_valid. s_rdata <= read_data, s_rresp from slv_err, ar_full cleared, s_rvalid <= 1, go to RD_RESP.
  - RD_RESP: hold R until s_rready, then go to IDLE.
- start_read and start_write are never high together.
- Buffers freed at completion may accept new requests during *_RESP. Those requests are not issued until IDLE.
- Latency: last of AW/W handshakes at edge N → start_write high from cycle N+2.
- Ignore strobes: done_write outside WR_REQ and read_data_valid outside RD_REQ have no effect.
- Responses only 2'b00 or 2'b10.

Optional Feature:
AXI_APB_FE_RR_ARB_EN
- Defined: round-robin arbitration.
  - A last_grant register (reset = write) records the last granted direction.
  - When both directions are eligible in IDLE, the direction opposite last_grant wins.
  - A single eligible direction always wins.
- Undefined: fixed read priority; the last_grant register is absent.

Test Plan:
1. W (data 0xDEADBEEF, strobe 0xF) one cycle before AW (addr 0x10, prot 3'b010); done_write with slv_err=0 two cycles after start → write_address=0x10, write_data=0xDEADBEEF, be=0xF, wprot=010 while start_write is high. start_write low the cycle after done_write. s_bvalid with s_bresp=00.
2. AR addr 0x20; read_data=0x12345678, read_data_valid with slv_err=1 → s_rdata=0x12345678, s_rresp=2'b10. s_rvalid held 4 cycles with s_rready=0, then drops after the handshake.
3. Write and read both eligible in the same IDLE cycle, macro undefined → read issued first, then write. Repeat twice with the macro defined → grants alternate R, W, R, W.
4. s_bready low 5 cycles in WR_RESP with a new AW+W arriving → new write buffered (awready/wready go low), start_write stays 0 until B handshake, then issues.
5. sys_areset pulsed during RD_REQ → start_read, s_rvalid low immediately; all buffers empty. A later read_data_valid produces no R response.
6. Stray done_write in IDLE → no s_bvalid, state unchanged.
